// File: rtl/pipeline_stall_ctrl_if.sv
// rtl/pipeline_stall_ctrl_if.sv - hazard/branch/memory handshake and pipeline control bundle
interface pipeline_stall_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  // Requests into the controller
  logic                 hazard_stall;
  logic                 branch_taken;
  logic                 mem_req;
  logic                 mem_ready;

  // Pipeline control back to the datapath
  logic                 pc_write;
  logic                 if_id_write;
  logic                 if_id_flush;
  logic                 id_ex_noop;
  logic                 ex_mem_write;
  logic                 mem_wb_noop;
  logic                 mem_timeout;

  // Performance counters
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic [CNT_WIDTH-1:0] load_use_count;
  logic [CNT_WIDTH-1:0] flush_count;

  // Datapath / hazard side
  modport master (
    output hazard_stall, branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_noop, ex_mem_write, mem_wb_noop,
    input  mem_timeout, stall_cycles, load_use_count, flush_count
  );

  // Controller side
  modport slave (
    input  hazard_stall, branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_noop, ex_mem_write, mem_wb_noop,
    output mem_timeout, stall_cycles, load_use_count, flush_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline freeze/flush controller with memory-wait timeout and perf counters
module pipeline_stall_ctrl #(
  parameter int CNT_WIDTH   = 32,
  parameter int WAIT_WIDTH  = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipeline_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

  state_t                state;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic                  mem_timeout;
  logic [CNT_WIDTH-1:0]  stall_cnt;
  logic [CNT_WIDTH-1:0]  load_use_cnt;
  logic [CNT_WIDTH-1:0]  flush_cnt;

  logic mem_freeze;
  logic apply_halt;
  logic apply_freeze;
  logic apply_stall;
  logic apply_flush;

  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_noop;
  logic ex_mem_write;
  logic mem_wb_noop;

  // Resolve which single action wins this cycle; a frozen MEM stage hides hazard and branch requests
  always_comb begin
    apply_halt   = (state == HALT);
    mem_freeze   = ((state == RUN) && bus.mem_req && !bus.mem_ready) ||
                   ((state == MEM_WAIT) && !bus.mem_ready);
    apply_freeze = !apply_halt && mem_freeze;
    apply_stall  = !apply_halt && !mem_freeze && bus.hazard_stall;
    apply_flush  = !apply_halt && !mem_freeze && !bus.hazard_stall && bus.branch_taken;
  end

  // Same-cycle pipeline controls; reset looks like a halted pipeline so nothing retires while held
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_noop   = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_noop  = 1'b0;
    if (!rst_i || apply_halt) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      id_ex_noop   = 1'b1;
      mem_wb_noop  = 1'b1;
    end else if (apply_freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_noop  = 1'b1;
    end else if (apply_stall) begin
      // The load-use bubble lets the older instructions drain through EX/MEM
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_noop   = 1'b1;
    end else if (apply_flush) begin
      if_id_flush  = 1'b1;
    end
  end

  // Memory-wait state machine: track how long the MEM access has been outstanding and halt on timeout
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.mem_req && !bus.mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_WIDTH'(1);
          end
        end
        MEM_WAIT: begin
          // The frozen pipeline keeps the request asserted, so only ready is watched here
          if (bus.mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state       <= HALT;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters; they stick at all-ones rather than wrapping
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt    <= '0;
      load_use_cnt <= '0;
      flush_cnt    <= '0;
    end else begin
      if ((apply_halt || apply_freeze || apply_stall) && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (apply_stall && (load_use_cnt != CNT_MAX))
        load_use_cnt <= load_use_cnt + CNT_WIDTH'(1);
      if (apply_flush && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.pc_write       = pc_write;
  assign bus.if_id_write    = if_id_write;
  assign bus.if_id_flush    = if_id_flush;
  assign bus.id_ex_noop     = id_ex_noop;
  assign bus.ex_mem_write   = ex_mem_write;
  assign bus.mem_wb_noop    = mem_wb_noop;
  assign bus.mem_timeout    = mem_timeout;
  assign bus.stall_cycles   = stall_cnt;
  assign bus.load_use_count = load_use_cnt;
  assign bus.flush_count    = flush_cnt;

endmodule
